// File: rtl/biu_prefetch_if.sv
// Memory-side bus of the prefetch BIU.
// The master drives registered strobes; the slave answers with ready and read data.
interface biu_prefetch_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/biu_prefetch.sv
// Bus interface unit: one memory port arbitrated between an instruction
// prefetch queue and a single data load/store channel, with branch flush.
module biu_prefetch #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 16,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    biu_prefetch_if.master              mem,
    output logic                        ifq_valid,
    output logic [DATA_W-1:0]           ifq_data,
    output logic [ADDR_W-1:0]           ifq_pc,
    input  logic                        ifq_pop,
    input  logic                        flush,
    input  logic [ADDR_W-1:0]           flush_pc,
    input  logic                        d_req,
    input  logic                        d_we,
    input  logic [ADDR_W-1:0]           d_addr,
    input  logic [DATA_W-1:0]           d_wdata,
    output logic                        d_ack,
    output logic [DATA_W-1:0]           d_rdata,
    output logic [$clog2(QDEPTH):0]     q_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t            state, next_state;
    logic              start_fetch, start_data, finish;
    logic              push, pop, stale;
    logic [ADDR_W-1:0] fetch_pc;
    logic [PW-1:0]     head, tail;
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];

    // Data requests win every IDLE decision; the ack cycle masks a still-held d_req.
    always_comb begin
        next_state  = state;
        start_fetch = 1'b0;
        start_data  = 1'b0;
        finish      = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req && !d_ack) begin
                    next_state = DATA;
                    start_data = 1'b1;
                end else if (!flush && q_count < FULL) begin
                    next_state  = FETCH;
                    start_fetch = 1'b1;
                end
            end
            FETCH, DATA: begin
                if (mem.mem_ready) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    assign push      = (state == FETCH) && mem.mem_ready && !stale && !flush;
    assign pop       = ifq_pop && (q_count != '0);
    assign ifq_valid = (q_count != '0);
    assign ifq_data  = q_data[head];
    assign ifq_pc    = q_pc[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_addr  <= '0;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_wdata <= '0;
            d_ack         <= 1'b0;
            d_rdata       <= '0;
        end else begin
            d_ack <= finish && (state == DATA);
            if (start_fetch) begin
                mem.mem_addr <= fetch_pc;
                mem.mem_rd   <= 1'b1;
            end else if (start_data) begin
                mem.mem_addr  <= d_addr;
                mem.mem_rd    <= !d_we;
                mem.mem_wr    <= d_we;
                mem.mem_wdata <= d_we ? d_wdata : '0;
            end else if (finish) begin
                mem.mem_rd    <= 1'b0;
                mem.mem_wr    <= 1'b0;
                mem.mem_wdata <= '0;
                if (state == DATA && mem.mem_rd) d_rdata <= mem.mem_rdata;
            end
        end
    end

    // A flush during a fetch lets the bus cycle finish but drops its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            stale    <= 1'b0;
            head     <= '0;
            tail     <= '0;
            q_count  <= '0;
        end else begin
            if (start_fetch)                 stale <= 1'b0;
            else if (flush && state == FETCH) stale <= 1'b1;

            if (flush) begin
                fetch_pc <= flush_pc;
                head     <= '0;
                tail     <= '0;
                q_count  <= '0;
            end else begin
                if (push) begin
                    tail     <= tail + 1'b1;
                    fetch_pc <= fetch_pc + 1'b1;
                end
                if (pop) head <= head + 1'b1;
                if (push && !pop)      q_count <= q_count + 1'b1;
                else if (pop && !push) q_count <= q_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= mem.mem_rdata;
            q_pc[tail]   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_biu_prefetch.sv
// Directed bench for biu_prefetch: a queue-based reference model checked every
// cycle, plus literal expectations for fill, pop, arbitration, load, flush, wrap and reset.
`timescale 1ns/1ps
module tb_biu_prefetch;
    localparam int QDEPTH = 4;
    localparam int CW     = $clog2(QDEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          ifq_valid, d_ack;
    logic [7:0]    ifq_data, d_rdata;
    logic [15:0]   ifq_pc;
    logic [CW-1:0] q_count;
    logic          ifq_pop  = 1'b0;
    logic          flush    = 1'b0;
    logic [15:0]   flush_pc = '0;
    logic          d_req    = 1'b0;
    logic          d_we     = 1'b0;
    logic [15:0]   d_addr   = '0;
    logic [7:0]    d_wdata  = '0;

    logic          use_ovr   = 1'b0;
    logic [7:0]    ovr_data  = '0;
    logic          ready_drv = 1'b0;

    biu_prefetch_if #(.DATA_W(8), .ADDR_W(16)) mem ();
    assign mem.mem_rdata = use_ovr ? ovr_data : mem.mem_addr[7:0];
    assign mem.mem_ready = ready_drv;

    biu_prefetch #(.DATA_W(8), .ADDR_W(16), .QDEPTH(QDEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem(mem),
        .ifq_valid(ifq_valid), .ifq_data(ifq_data), .ifq_pc(ifq_pc), .ifq_pop(ifq_pop),
        .flush(flush), .flush_pc(flush_pc),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .q_count(q_count)
    );

    // Second instance only exercises the reset fetch address and its wrap.
    logic          tie0   = 1'b0;
    logic [15:0]   tie16  = '0;
    logic [7:0]    tie8   = '0;
    logic          ifq_valid2, d_ack2;
    logic [7:0]    ifq_data2, d_rdata2;
    logic [15:0]   ifq_pc2;
    logic [CW-1:0] q_count2;

    biu_prefetch_if #(.DATA_W(8), .ADDR_W(16)) mem2 ();
    assign mem2.mem_ready = 1'b1;
    assign mem2.mem_rdata = mem2.mem_addr[7:0];

    biu_prefetch #(.DATA_W(8), .ADDR_W(16), .QDEPTH(QDEPTH), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst), .mem(mem2),
        .ifq_valid(ifq_valid2), .ifq_data(ifq_data2), .ifq_pc(ifq_pc2), .ifq_pop(tie0),
        .flush(tie0), .flush_pc(tie16),
        .d_req(tie0), .d_we(tie0), .d_addr(tie16), .d_wdata(tie8),
        .d_ack(d_ack2), .d_rdata(d_rdata2), .q_count(q_count2)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Memory responder: ready arrives wait_states cycles after a strobe rises.
    int   wait_states = 0;
    int   age         = 0;
    logic last_strobe = 1'b0;
    always @(posedge clk) begin
        #1;
        if (mem.mem_rd || mem.mem_wr) begin
            age         = last_strobe ? age + 1 : 0;
            last_strobe = 1'b1;
        end else begin
            age         = 0;
            last_strobe = 1'b0;
        end
        ready_drv = (mem.mem_rd || mem.mem_wr) && (age >= wait_states);
    end

    typedef struct { logic wr; logic [15:0] addr; logic [7:0] wdata; } acc_t;
    acc_t        acc_log[$];
    logic [15:0] log2[$];
    logic        prev_s = 1'b0, prev_s2 = 1'b0;
    always @(negedge clk) begin
        if ((mem.mem_rd || mem.mem_wr) && !prev_s)
            acc_log.push_back('{mem.mem_wr, mem.mem_addr, mem.mem_wdata});
        prev_s = mem.mem_rd || mem.mem_wr;
        if (mem2.mem_rd && !prev_s2) log2.push_back(mem2.mem_addr);
        prev_s2 = mem2.mem_rd;
    end

    // Reference model: queue contents, fetch pointer and the access on the bus.
    typedef struct { logic [15:0] pc; logic [7:0] data; } ent_t;
    ent_t        mq[$];
    int          m_bus = 0;
    logic        m_stale, m_we, m_ack, ack_next, can_pop, pushing;
    logic [15:0] m_addr, m_fpc;
    logic [7:0]  m_wdata, m_rdata, rd_v;
    bit          model_ok = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("mem_rd", mem.mem_rd, (m_bus == 1) || (m_bus == 2 && !m_we));
            checkOutput("mem_wr", mem.mem_wr, (m_bus == 2) && m_we);
            checkOutput("mem_wdata", mem.mem_wdata, (m_bus == 2 && m_we) ? m_wdata : 8'h00);
            if (m_bus != 0) checkOutput("mem_addr", mem.mem_addr, m_addr);
            checkOutput("d_ack", d_ack, m_ack);
            checkOutput("d_rdata", d_rdata, m_rdata);
            checkOutput("q_count", q_count, mq.size());
            checkOutput("ifq_valid", ifq_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                checkOutput("ifq_pc", ifq_pc, mq[0].pc);
                checkOutput("ifq_data", ifq_data, mq[0].data);
            end
        end
        if (rst) begin
            mq.delete();
            m_bus = 0; m_stale = 0; m_we = 0; m_ack = 0;
            m_addr = '0; m_fpc = 16'h0000; m_wdata = '0; m_rdata = '0;
            model_ok = 1;
        end else if (model_ok) begin
            ack_next = 1'b0;
            pushing  = 1'b0;
            can_pop  = ifq_pop && (mq.size() != 0);
            rd_v     = mem.mem_rdata;
            if (m_bus == 0) begin
                if (d_req && !m_ack) begin
                    m_bus = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                end else if (!flush && mq.size() < QDEPTH) begin
                    m_bus = 1; m_addr = m_fpc; m_stale = 1'b0;
                end
            end else if (mem.mem_ready) begin
                if (m_bus == 1 && !m_stale && !flush) pushing = 1'b1;
                if (m_bus == 2) begin
                    ack_next = 1'b1;
                    if (!m_we) m_rdata = rd_v;
                end
                m_bus = 0;
            end else if (m_bus == 1 && flush) begin
                m_stale = 1'b1;
            end
            if (flush) begin
                mq.delete();
                m_fpc = flush_pc;
            end else begin
                if (can_pop) void'(mq.pop_front());
                if (pushing) begin
                    mq.push_back('{m_fpc, rd_v});
                    m_fpc = m_fpc + 16'd1;
                end
            end
            m_ack = ack_next;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen, rd_cycles, base;
        applyStimulus(3);
        checkOutput("reset_q_count", q_count, 0);
        checkOutput("reset_ifq_valid", ifq_valid, 0);
        checkOutput("reset_mem_rd", mem.mem_rd, 0);
        checkOutput("reset_d_ack", d_ack, 0);
        rst = 1'b0;

        // Fill: fetches at 0..3 with ready tied high
        seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            applyStimulus(1);
            if (q_count == 3'd4) seen = 1;
        end
        checkOutput("fill_done", seen, 1);
        applyStimulus(4);
        checkOutput("full_q_count", q_count, 4);
        checkOutput("full_mem_rd", mem.mem_rd, 0);
        checkOutput("full_head_pc", ifq_pc, 16'h0000);
        checkOutput("full_head_data", ifq_data, 8'h00);
        checkOutput("fill_fetches", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            checkOutput("fill_addr", acc_log[i].addr, i);
        checkOutput("wrap_count", log2.size(), 4);
        if (log2.size() >= 3) begin
            checkOutput("wrap_addr0", log2[0], 16'hFFFE);
            checkOutput("wrap_addr1", log2[1], 16'hFFFF);
            checkOutput("wrap_addr2", log2[2], 16'h0000);
        end
        checkOutput("wrap_head_pc", ifq_pc2, 16'hFFFE);
        checkOutput("wrap_q_count", q_count2, 4);

        // Single pop refills exactly one entry at address 4
        base = acc_log.size();
        ifq_pop = 1'b1; applyStimulus(1); ifq_pop = 1'b0;
        applyStimulus(6);
        checkOutput("pop_q_count", q_count, 4);
        checkOutput("pop_head_pc", ifq_pc, 16'h0001);
        checkOutput("pop_new_fetches", acc_log.size() - base, 1);
        if (acc_log.size() > base) checkOutput("pop_fetch_addr", acc_log[base].addr, 16'h0004);

        // Store requested while a slow fetch is in flight
        base = acc_log.size();
        wait_states = 3;
        ifq_pop = 1'b1; applyStimulus(2); ifq_pop = 1'b0;
        checkOutput("fetch5_in_flight", mem.mem_rd, 1);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 8'hA5;
        seen = 0;
        for (int n = 0; n < 30 && seen == 0; n++) begin
            applyStimulus(1);
            if (d_ack) seen = 1;
        end
        d_req = 1'b0; d_we = 1'b0;
        checkOutput("store_ack_seen", seen, 1);
        applyStimulus(1);
        checkOutput("store_ack_one_cycle", d_ack, 0);
        applyStimulus(3);
        checkOutput("store_accesses", acc_log.size() - base, 3);
        if (acc_log.size() >= base + 3) begin
            checkOutput("store_first_fetch", acc_log[base].addr, 16'h0005);
            checkOutput("store_first_is_rd", acc_log[base].wr, 0);
            checkOutput("store_addr", acc_log[base+1].addr, 16'h1234);
            checkOutput("store_is_wr", acc_log[base+1].wr, 1);
            checkOutput("store_wdata", acc_log[base+1].wdata, 8'hA5);
            checkOutput("store_next_fetch", acc_log[base+2].addr, 16'h0006);
        end

        // Load with two wait states, request held through the ack cycle
        applyStimulus(20);
        base = acc_log.size();
        wait_states = 2; use_ovr = 1'b1; ovr_data = 8'h5C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h8000;
        seen = 0; rd_cycles = 0;
        for (int n = 0; n < 30 && seen == 0; n++) begin
            applyStimulus(1);
            if (mem.mem_rd) rd_cycles++;
            if (d_ack) seen = 1;
        end
        checkOutput("load_ack_seen", seen, 1);
        checkOutput("load_rd_cycles", rd_cycles, 3);
        checkOutput("load_rdata", d_rdata, 8'h5C);
        applyStimulus(1);
        d_req = 1'b0;
        checkOutput("load_no_reissue", mem.mem_rd, 0);
        applyStimulus(3);
        checkOutput("load_accesses", acc_log.size() - base, 1);
        if (acc_log.size() > base) checkOutput("load_addr", acc_log[base].addr, 16'h8000);
        use_ovr = 1'b0;

        // Flush while fetch of 0x0007 is in flight with two entries queued
        base = acc_log.size();
        wait_states = 3;
        ifq_pop = 1'b1; applyStimulus(2); ifq_pop = 1'b0;
        checkOutput("flush_pre_count", q_count, 2);
        checkOutput("flush_pre_rd", mem.mem_rd, 1);
        checkOutput("flush_pre_addr", mem.mem_addr, 16'h0007);
        flush = 1'b1; flush_pc = 16'h0100;
        applyStimulus(1);
        flush = 1'b0;
        checkOutput("flush_q_count", q_count, 0);
        checkOutput("flush_valid", ifq_valid, 0);
        applyStimulus(12);
        checkOutput("flush_refill_valid", ifq_valid, 1);
        checkOutput("flush_head_pc", ifq_pc, 16'h0100);
        checkOutput("flush_head_data", ifq_data, 8'h00);
        if (acc_log.size() >= base + 2) begin
            checkOutput("flush_stale_addr", acc_log[base].addr, 16'h0007);
            checkOutput("flush_next_addr", acc_log[base+1].addr, 16'h0100);
        end else begin
            checkOutput("flush_accesses", acc_log.size() - base, 2);
        end

        // Reset in the middle of a slow load
        applyStimulus(15);
        wait_states = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4444;
        applyStimulus(2);
        checkOutput("pre_reset_rd", mem.mem_rd, 1);
        checkOutput("pre_reset_addr", mem.mem_addr, 16'h4444);
        rst = 1'b1; d_req = 1'b0;
        applyStimulus(1);
        rst = 1'b0;
        checkOutput("rst_mem_rd", mem.mem_rd, 0);
        checkOutput("rst_mem_wr", mem.mem_wr, 0);
        checkOutput("rst_mem_addr", mem.mem_addr, 16'h0000);
        checkOutput("rst_mem_wdata", mem.mem_wdata, 8'h00);
        checkOutput("rst_d_ack", d_ack, 0);
        checkOutput("rst_d_rdata", d_rdata, 8'h00);
        checkOutput("rst_q_count", q_count, 0);
        checkOutput("rst_ifq_valid", ifq_valid, 0);
        applyStimulus(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/biu_prefetch.md
Name: biu_prefetch

Overview:
- Parametrised bus interface unit for the next-generation JAVK core.
- Replaces the ad hoc fetch/address muxing with a single arbitrated memory port: instruction prefetch queue plus one data load/store channel.
- Generalised data and address widths, a configurable prefetch depth, a ready-based wait-state handshake, and a branch flush.

Parameters:
- DATA_W, 8, data bus width in bits.
- ADDR_W, 16, address bus width in bits.
- QDEPTH, 4, prefetch queue entries; power of 2, minimum 2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR_W  memory address; registered.
- mem_rd  out  1  read strobe; registered.
- mem_wr  out  1  write strobe; registered.
- mem_wdata  out  DATA_W  write data; registered, 0 when mem_wr=0.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.
- mem_ready  in  1  access completes in the cycle this is high.
- ifq_valid  out  1  queue non-empty.
- ifq_data  out  DATA_W  head instruction byte.
- ifq_pc  out  ADDR_W  address of the head byte.
- ifq_pop  in  1  consume the head entry.
- flush  in  1  discard the queue and redirect fetch.
- flush_pc  in  ADDR_W  new fetch address.
- d_req  in  1  data access request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load result; held until the next load completes.
- q_count  out  $clog2(QDEPTH)+1  queue occupancy.

Behaviour:
- Reset state: state=IDLE, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, d_ack=0, d_rdata=0, queue empty (q_count=0, ifq_valid=0), fetch_pc=RESET_PC.
- Reset wins over every other input. Reset during a bus access abandons it; strobes are 0 after that edge.
- FSM states: IDLE, FETCH, DATA.
- IDLE transitions, evaluated in priority order:
  - d_req=1 and d_ack=0 -> DATA. Latch d_we, d_addr, d_wdata. Drive mem_addr=d_addr and mem_rd=!d_we / mem_wr=d_we from the next cycle.
  - Otherwise, flush=0 and q_count<QDEPTH -> FETCH. Drive mem_addr=fetch_pc, mem_rd=1.
  - Otherwise, stay in IDLE.
- Bus cycle rules:
  - Address, strobe and wdata are held stable until the cycle in which mem_ready=1. That edge completes the access.
  - Strobes deassert on the completion edge and the FSM returns to IDLE.
  - Minimum 2 cycles per access; no back-to-back strobes.
- FETCH completion, not stale:
  - Push {fetch_pc, mem_rdata} into the queue.
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000 for ADDR_W=16).
  - A free slot is guaranteed, because a fetch only starts when q_count<QDEPTH and the queue only shrinks while it is in flight.
- DATA completion:
  - d_ack=1 for exactly the following cycle.
  - For a load, d_rdata <= mem_rdata.
  - d_req is ignored while d_ack=1, so a request still held during the ack cycle is not re-executed. It is re-accepted in the next cycle if still asserted.
- Arbitration:
  - Data access has priority over fetch at every IDLE decision.
  - An in-flight fetch is never aborted by d_req; the data access waits for it to complete.
- Queue:
  - Circular buffer; ifq_data/ifq_pc show the head combinationally.
  - ifq_pop with an empty queue is ignored.
  - Push and pop in the same cycle leave q_count unchanged.
- Flush:
  - Next cycle: q_count=0, fetch_pc=flush_pc.
  - Flush overrides a coincident pop and a coincident push.
  - If a FETCH is in flight, it runs to completion on the bus, but its data is marked stale and is not pushed, and fetch_pc is not incremented.
  - Flush does not affect a DATA access.
- Outputs mem_* and d_ack are registered; no combinational path from mem_ready to any strobe.

Test Plan:
- Reset, then mem_ready tied 1, mem_rdata=addr[7:0], no pops -> fetches at 0,1,2,3 (one every 2 cycles); q_count reaches 4; mem_rd stays 0 while the queue is full; ifq_pc=0, ifq_data=0x00.
- Full queue, pop once -> exactly one new fetch at address 4; q_count returns to 4; head becomes pc=1.
- d_req store addr=0x1234, wdata=0xA5 asserted during a fetch with mem_ready delayed 3 cycles -> fetch completes first; then mem_wr=1, mem_addr=0x1234, mem_wdata=0xA5; d_ack one cycle; the next fetch waits until after that.
- Load from 0x8000 returning 0x5C with 2 wait states -> mem_rd held 3 cycles at a stable address; d_rdata=0x5C with d_ack; d_req still high during ack is not reissued in that cycle.
- flush with flush_pc=0x0100 while a fetch of 0x0007 is in flight and 2 entries are queued -> q_count=0 next cycle; data for 0x0007 discarded; next fetch address 0x0100; the first queued entry has ifq_pc=0x0100.
- RESET_PC=0xFFFE -> fetches at 0xFFFE, 0xFFFF, 0x0000 (wrap); rst asserted mid-access -> strobes 0 and all outputs at reset values next cycle.
